pll_lock_detect: RTL and testbench

Lock detector and frequency monitor on the receive side of the PLL output. It runs entirely in the `pclk` domain and samples `refclk` as asynchronous data. For every reference period it counts `pclk` cycles and compares the count against the programmed ratio `n`. A hysteretic state machine turns the resulting good/bad measurements into `locked`, and a reference-loss watchdog asserts `ref_lost` when reference edges stop.

---
 rtl/pll_lock_detect.sv | 137 +++++++++++++
 tb/tb_pll_lock_detect.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_detect.sv
// PLL lock detector and frequency monitor in the pclk domain: measures each
// refclk period in pclk cycles, applies lock/unlock hysteresis, and watches for reference loss.
module pll_lock_detect #(
  parameter int CW         = 10,
  parameter int NW         = 8,
  parameter int TW         = 4,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 2
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          refclk,
  input  logic [NW-1:0] n,
  input  logic [TW-1:0] tol,
  output logic          locked,
  output logic          ref_lost,
  output logic          meas_valid,
  output logic [CW-1:0] meas_count,
  output logic [CW:0]   freq_err
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ACQ, SEARCH, LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  function automatic logic [CW:0] abs_err(input logic signed [CW:0] e);
    logic signed [CW:0] neg;
    neg = -e;
    return e[CW] ? $unsigned(neg) : $unsigned(e);
  endfunction

  state_t               state;
  logic                 s1, s2, s3;
  logic [CW-1:0]        cnt;
  logic [GW-1:0]        good_cnt;
  logic [BW-1:0]        bad_cnt;

  logic                 vld_p0;
  logic [CW-1:0]        m_p0;
  logic signed [CW:0]   err_p0;
  logic                 good_p0;

  logic                 vld_p1;
  logic [CW-1:0]        meas_p1;
  logic signed [CW:0]   err_p1;

  // Stage p0: edge cycle, measurement and tolerance test
  always_comb begin
    vld_p0  = s2 & ~s3;
    m_p0    = sat_inc(cnt);
    err_p0  = $signed({1'b0, m_p0}) - $signed({{(CW+1-NW){1'b0}}, n});
    good_p0 = (abs_err(err_p0) <= {{(CW+1-TW){1'b0}}, tol});
  end

  // Stage p1: registered publication, hysteresis FSM and watchdog
  always_ff @(posedge pclk) begin
    if (reset) begin
      state    <= ACQ;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      cnt      <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      locked   <= 1'b0;
      ref_lost <= 1'b0;
      vld_p1   <= 1'b0;
      meas_p1  <= '0;
      err_p1   <= '0;
    end else begin
      s1     <= refclk;
      s2     <= s1;
      s3     <= s2;
      vld_p1 <= 1'b0;
      cnt    <= vld_p0 ? '0 : sat_inc(cnt);
      if (vld_p0) begin
        // An edge in the saturation cycle is a measurement, never a loss.
        case (state)
          ACQ: begin
            state    <= SEARCH;
            ref_lost <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end
          SEARCH: begin
            vld_p1  <= 1'b1;
            meas_p1 <= m_p0;
            err_p1  <= err_p0;
            if (!good_p0) begin
              good_cnt <= '0;
            end else if (good_cnt == GW'(LOCK_CNT - 1)) begin
              good_cnt <= GW'(LOCK_CNT);
              state    <= LOCKED;
              locked   <= 1'b1;
              bad_cnt  <= '0;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end
          LOCKED: begin
            vld_p1  <= 1'b1;
            meas_p1 <= m_p0;
            err_p1  <= err_p0;
            if (good_p0) begin
              bad_cnt <= '0;
            end else if (bad_cnt == BW'(UNLOCK_CNT - 1)) begin
              bad_cnt  <= '0;
              state    <= SEARCH;
              locked   <= 1'b0;
              good_cnt <= '0;
            end else begin
              bad_cnt <= bad_cnt + BW'(1);
            end
          end
          default: state <= ACQ;
        endcase
      end else if (cnt == CNT_MAX) begin
        state    <= ACQ;
        ref_lost <= 1'b1;
        locked   <= 1'b0;
        good_cnt <= '0;
        bad_cnt  <= '0;
      end
    end
  end

  assign meas_valid = vld_p1;
  assign meas_count = meas_p1;
  assign freq_err   = err_p1;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Bench for pll_lock_detect: table of refclk periods with expected lock state,
// a publication scoreboard, and hand sequences for loss, saturation and reset.
module tb_pll_lock_detect;
  localparam int CW  = 10;
  localparam int NW  = 8;
  localparam int TW  = 4;
  localparam int SAT = 1023;

  logic          pclk = 1'b0;
  logic          reset;
  logic          refclk;
  logic [NW-1:0] n;
  logic [TW-1:0] tol;
  logic          locked;
  logic          ref_lost;
  logic          meas_valid;
  logic [CW-1:0] meas_count;
  logic [CW:0]   freq_err;

  pll_lock_detect #(.CW(CW), .NW(NW), .TW(TW), .LOCK_CNT(8), .UNLOCK_CNT(2)) dut (
    .pclk(pclk), .reset(reset), .refclk(refclk), .n(n), .tol(tol),
    .locked(locked), .ref_lost(ref_lost), .meas_valid(meas_valid),
    .meas_count(meas_count), .freq_err(freq_err)
  );

  always #5 pclk = ~pclk;

  typedef struct { int cnt; int err; bit lk; } exp_t;
  typedef struct { int len; int nn; int tt; bit pub; bit lk; } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_rise = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Every publication must match the oldest outstanding expectation.
  always @(negedge pclk) begin
    if (meas_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_meas_valid", int'(meas_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        check("meas_count", int'(meas_count), mon_e.cnt);
        check("freq_err", int'($signed(freq_err)), mon_e.err);
        check("locked_at_pub", int'(locked), int'(mon_e.lk));
      end
    end
  end

  task automatic add(input int len, input int nn, input int tt, input bit pub, input bit lk);
    vec_t v;
    v.len = len; v.nn = nn; v.tt = tt; v.pub = pub; v.lk = lk;
    tbl.push_back(v);
  endtask

  // Rise refclk now; the expectation covers the period that just ended.
  task automatic start_edge(input int nn, input int tt, input bit pub, input bit lk);
    int   lp;
    exp_t e;
    lp        = cyc - last_rise;
    last_rise = cyc;
    n         = nn[NW-1:0];
    tol       = tt[TW-1:0];
    refclk    = 1'b1;
    if (pub) begin
      e.cnt = (lp > SAT) ? SAT : lp;
      e.err = e.cnt - nn;
      e.lk  = lk;
      sb.push_back(e);
    end
  endtask

  task automatic do_edge(input int len, input int nn, input int tt, input bit pub, input bit lk);
    start_edge(nn, tt, pub, lk);
    repeat (len / 2) @(negedge pclk);
    refclk = 1'b0;
    repeat (len - len / 2) @(negedge pclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_ref_lost"}, int'(ref_lost), 0);
    check({tag, "_meas_valid"}, int'(meas_valid), 0);
    check({tag, "_meas_count"}, int'(meas_count), 0);
    check({tag, "_freq_err"}, int'(freq_err), 0);
  endtask

  initial begin
    reset = 1'b1; refclk = 1'b0; n = '0; tol = '0;
    repeat (3) @(negedge pclk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge pclk);

    // len = period following this edge; lk = locked expected at its publication
    add(32, 32, 1, 0, 0);
    for (int k = 2; k <= 8; k++) add(32, 32, 1, 1, 0);
    add(32, 32, 1, 1, 1);
    add(40, 32, 1, 1, 1);
    add(32, 32, 1, 1, 1);
    add(40, 32, 1, 1, 1);
    add(40, 32, 1, 1, 1);
    add(32, 32, 1, 1, 0);
    for (int k = 15; k <= 21; k++) add(32, 32, 1, 1, 0);
    add(34, 32, 1, 1, 1);
    add(34, 32, 1, 1, 1);
    add(34, 32, 1, 1, 0);
    add(34, 32, 1, 1, 0);
    add(31, 32, 1, 1, 0);
    for (int k = 27; k <= 33; k++) add(31, 32, 1, 1, 0);
    add(32, 32, 1, 1, 1);
    add(32, 30, 2, 1, 1);
    add(32, 30, 1, 1, 1);
    add(32, 32, 1, 1, 1);
    foreach (tbl[i]) do_edge(tbl[i].len, tbl[i].nn, tbl[i].tt, tbl[i].pub, tbl[i].lk);

    // Reference loss: last edge, then refclk held low
    start_edge(32, 1, 1, 1);
    repeat (3) @(negedge pclk);
    repeat (13) @(negedge pclk);
    refclk = 1'b0;
    repeat (1010) @(negedge pclk);
    check("loss_ref_lost_early", int'(ref_lost), 0);
    check("loss_locked_early", int'(locked), 1);
    @(negedge pclk);
    check("loss_ref_lost", int'(ref_lost), 1);
    check("loss_locked", int'(locked), 0);
    repeat (5) @(negedge pclk);

    // Restart: first edge only clears ref_lost
    start_edge(32, 1, 0, 0);
    repeat (2) @(negedge pclk);
    check("restart_ref_lost_hold", int'(ref_lost), 1);
    @(negedge pclk);
    check("restart_ref_lost_clear", int'(ref_lost), 0);
    check("restart_locked", int'(locked), 0);
    repeat (13) @(negedge pclk);
    refclk = 1'b0;
    repeat (16) @(negedge pclk);
    for (int k = 2; k <= 9; k++) do_edge(32, 32, 1, 1, k == 9);

    // Edge exactly in the saturation cycle, then one cycle too late
    do_edge(1024, 32, 1, 1, 1);
    start_edge(32, 1, 1, 1);
    repeat (2) @(negedge pclk);
    check("sat_ref_lost_edge", int'(ref_lost), 0);
    @(negedge pclk);
    check("sat_ref_lost_pub", int'(ref_lost), 0);
    repeat (13) @(negedge pclk);
    refclk = 1'b0;
    repeat (1009) @(negedge pclk);
    start_edge(32, 1, 0, 0);
    repeat (2) @(negedge pclk);
    check("late_ref_lost", int'(ref_lost), 1);
    check("late_locked", int'(locked), 0);
    @(negedge pclk);
    check("late_ref_lost_clear", int'(ref_lost), 0);
    repeat (13) @(negedge pclk);
    refclk = 1'b0;
    repeat (16) @(negedge pclk);
    for (int k = 1; k <= 8; k++) do_edge(32, 32, 1, 1, k == 8);

    // Reset pulse while locked, then reacquire from ACQ
    start_edge(32, 1, 1, 1);
    repeat (16) @(negedge pclk);
    refclk = 1'b0;
    repeat (4) @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
    check_all_zero("midreset");
    repeat (10) @(negedge pclk);
    do_edge(32, 32, 1, 0, 0);
    for (int k = 2; k <= 9; k++) do_edge(32, 32, 1, 1, k == 9);
    repeat (5) @(negedge pclk);
    check("relock_final", int'(locked), 1);
    check("pending_publications", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
